// File: rtl/multiport_register_file.sv
// Parametrised multi-port register file: byte-strobed write port, NUM_READ
// read ports with optional write bypass and optional output register,
// optional hardwired-zero register 0 and a one-register-per-cycle clear sweep.

// One read port: addressed lookup, register-0 suppression and write bypass.
module multiport_register_file_rd_port #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ZERO_REG0  = 1,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs,
    input  logic [AW-1:0]                    addr,
    input  logic                             wr_acc,
    input  logic [AW-1:0]                    wr_reg,
    input  logic [DATA_WIDTH-1:0]            wr_merged,
    output logic [DATA_WIDTH-1:0]            rd_val
);

    // wr_acc already excludes suppressed register-0 writes, so the bypass
    // override can never resurrect a nonzero register 0.
    always_comb begin
        rd_val = regs[addr];
        if (ZERO_REG0 != 0 && addr == '0)
            rd_val = '0;
        if (BYPASS != 0 && wr_acc && wr_reg == addr)
            rd_val = wr_merged;
    end

endmodule

module multiport_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int NUM_READ   = 2,
    parameter int ZERO_REG0  = 1,
    parameter int BYPASS     = 1,
    parameter int READ_REG   = 0,
    localparam int AW        = $clog2(DEPTH),
    localparam int SW        = DATA_WIDTH / 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           write_enable,
    input  logic [AW-1:0]                  write_reg,
    input  logic [DATA_WIDTH-1:0]          write_data,
    input  logic [SW-1:0]                  write_strobe,
    input  logic [NUM_READ*AW-1:0]         read_regs,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
    input  logic                           clear_req,
    output logic                           busy
);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SWEEP = 1'b1;

    logic [0:0]                           state;
    logic [AW-1:0]                        ptr;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]     regs;
    logic [DATA_WIDTH-1:0]                wr_merged;
    logic                                 wr_acc;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_val;
    logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rd_q;

    assign busy   = (state == SWEEP);
    // Writes are only taken while idle; register-0 writes vanish when hardwired.
    assign wr_acc = write_enable && (state == IDLE) &&
                    !(ZERO_REG0 != 0 && write_reg == '0);

    // Stored word with the strobed bytes replaced; shared by write and bypass.
    always_comb begin
        wr_merged = regs[write_reg];
        for (int i = 0; i < SW; i++)
            if (write_strobe[i])
                wr_merged[8*i +: 8] = write_data[8*i +: 8];
    end

    // Clear-sweep sequencer: one register zeroed per cycle, pointer wraps to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
        end else if (state == IDLE) begin
            if (clear_req) begin
                state <= SWEEP;
                ptr   <= '0;
            end
        end else begin
            ptr <= ptr + 1'b1;
            if (ptr == AW'(DEPTH - 1))
                state <= IDLE;
        end
    end

    // Register storage: sweep zeroing has priority, writes only when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (state == SWEEP)
            regs[ptr] <= '0;
        else if (wr_acc)
            regs[write_reg] <= wr_merged;
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
        multiport_register_file_rd_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .DEPTH      (DEPTH),
            .ZERO_REG0  (ZERO_REG0),
            .BYPASS     (BYPASS)
        ) u_rd (
            .regs      (regs),
            .addr      (read_regs[p*AW +: AW]),
            .wr_acc    (wr_acc),
            .wr_reg    (write_reg),
            .wr_merged (wr_merged),
            .rd_val    (rd_val[p])
        );
    end

    // Optional output register; it folds away when READ_REG selects the comb path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_q <= '0;
        else
            rd_q <= rd_val;
    end

    assign read_data = (READ_REG != 0) ? rd_q : rd_val;

endmodule

// File: doc/multiport_register_file.md
# multiport_register_file

Parametrised register file for the processor datapath, the successor of the fixed two-read/one-write 32x32 register file. Adds configurable width, depth and read-port count, per-byte write strobes, optional hardwired-zero register 0, write-to-read bypass, selectable combinational or registered reads, and a hardware clear sweep. It sits between decode (read addresses) and writeback (write port).

## Interface
- DATA_WIDTH, 32, bits per register; multiple of 8
- DEPTH, 32, number of registers; power of two, >= 2
- NUM_READ, 2, number of read ports, 1..8
- ZERO_REG0, 1, 1: register 0 reads 0 and ignores writes
- BYPASS, 1, 1: same-cycle write data forwarded to matching read ports
- READ_REG, 0, 0: combinational read; 1: read data registered (1-cycle latency)
- Derived: AW = clog2(DEPTH), SW = DATA_WIDTH/8

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- write_enable  in  1  write request
- write_reg  in  AW  write address
- write_data  in  DATA_WIDTH  write data
- write_strobe  in  SW  byte enables; bit i covers bits [8i+7:8i]
- read_regs  in  NUM_READ*AW  read addresses; port p at [p*AW +: AW]
- read_data  out  NUM_READ*DATA_WIDTH  read data; port p at [p*DATA_WIDTH +: DATA_WIDTH]
- clear_req  in  1  start clear sweep (sampled when idle)
- busy  out  1  clear sweep in progress

## Operation
- Reset (rst_n=0, asynchronous): all registers 0, registered read_data 0, busy 0, FSM IDLE, sweep pointer 0.
- Write: at edge with write_enable=1 and FSM IDLE, bytes with strobe=1 updated, others kept. Strobe all-zero = no change. With ZERO_REG0=1, writes to address 0 dropped.
- Read port p: value of register read_regs[p]; address 0 with ZERO_REG0=1 always 0.
- Bypass (BYPASS=1): if write is accepted this cycle and write_reg equals port address (and not suppressed reg0), port returns stored value with strobed bytes replaced by write_data. BYPASS=0: port returns pre-write stored value.
- READ_REG=0: read_data combinational from addresses/state. READ_REG=1: the same value is captured at the edge and presented the following cycle.
- FSM: IDLE -> SWEEP when clear_req=1 at an edge in IDLE; pointer set to 0. In SWEEP each edge zeroes register[pointer] and increments pointer; after clearing DEPTH-1, -> IDLE. busy = (state==SWEEP).
- During SWEEP: writes ignored (no bypass); clear_req ignored; reads return current stored contents (registers below pointer already 0).
- Simultaneous clear_req and write in IDLE: write is performed at that edge; sweep then clears it.
- Multiple read ports may address the same register; all return identical data.

## Timing
- Write latency: data visible to non-bypassed combinational read the cycle after the write edge.
- Bypassed read: same cycle (READ_REG=0) or next cycle (READ_REG=1).
- busy rises one edge after clear_req accepted; stays high exactly DEPTH cycles; first write accepted on the edge where busy=0 is sampled.
- Reset mid-sweep: immediate return to IDLE, all registers 0, busy 0.
- Reset deassertion: first write possible on the first rising edge with rst_n=1.

## Test plan
- Defaults: write 10 to reg 20 (strobe 4'hF), next cycle read port 0 addr 20 -> 10; writing 120 with write_enable=0 -> reg 20 still 10.
- Bypass: write 32'hDEADBEEF strobe 4'b0011 to reg 1 holding 32'h11223344, port 1 addr 1 same cycle -> 32'h1122BEEF; with BYPASS=0 -> 32'h11223344, then 32'h1122BEEF next cycle.
- Reg 0: write 55 to reg 0 -> reads 0 with ZERO_REG0=1; reads 55 with ZERO_REG0=0.
- READ_REG=1, NUM_READ=4: all four ports address reg 7 holding 9 -> all read_data 0 in the address cycle's edge-preceding value, 9 one cycle later; after reset read_data all 0.
- Clear: fill regs 0..31 with index+1, pulse clear_req -> busy high 32 cycles, writes during busy ignored, all regs read 0 after; clear_req while busy does not extend busy.
- Reset mid-sweep at pointer 10 -> busy 0 immediately, all regs 0, write accepted next edge.
